// File: rtl/dual_issue_scheduler_pkg.sv
// Shared definitions for the 2-wide decode issue scheduler and its hazard checker.
package dual_issue_scheduler_pkg;

   localparam int REG_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_ISSUE   = 2'd0,
      ST_SPLIT   = 2'd1,
      ST_MD_WAIT = 2'd2
   } sched_state_e;

endpackage

// File: rtl/issue_hazard_check.sv
// Combinational hazard terms for the decoded pair: load-use per slot and the
// pair-blocking condition that forces slot1 to issue a cycle after slot0.
module issue_hazard_check
   import dual_issue_scheduler_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic [REG_W-1:0] s0_rs,
   input  logic [REG_W-1:0] s0_rt,
   input  logic [REG_W-1:0] s0_rd,
   input  logic [REG_W-1:0] s1_rs,
   input  logic [REG_W-1:0] s1_rt,
   input  logic [REG_W-1:0] s1_rd,
   input  logic             s0_wr,
   input  logic             s0_mem,
   input  logic             s1_mem,
   input  logic             s0_cf,
   input  logic             s0_md,
   input  logic             s1_md,
   input  logic             ex_ld0,
   input  logic             ex_ld1,
   input  logic [REG_W-1:0] ex_rd0,
   input  logic [REG_W-1:0] ex_rd1,
   output logic             luse0,
   output logic             luse1,
   output logic             pairblk
);

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   function automatic logic ld_hit(input logic ld, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt);
      return ld && (rd != '0) && ((rd == rs) || (rd == rt));
   endfunction

   logic pairdep;

   always_comb begin
      luse0   = ld_hit(ex_ld0, ex_rd0, s0_rs, s0_rt) || ld_hit(ex_ld1, ex_rd1, s0_rs, s0_rt);
      luse1   = ld_hit(ex_ld0, ex_rd0, s1_rs, s1_rt) || ld_hit(ex_ld1, ex_rd1, s1_rs, s1_rt);
      pairdep = s0_wr && (s0_rd != '0) &&
                ((s0_rd == s1_rs) || (s0_rd == s1_rt) || (s0_rd == s1_rd));
      pairblk = pairdep || (s0_mem && s1_mem) || (s0_md && s1_md) || s0_cf;
   end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Decode-stage issue scheduler for the 2-wide pipeline: splits hazardous pairs,
// sequences the shared mult/div unit and counts decode stall cycles.
module dual_issue_scheduler
   import dual_issue_scheduler_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             dec_valid,
   input  logic [REG_W-1:0] s0_rs,
   input  logic [REG_W-1:0] s0_rt,
   input  logic [REG_W-1:0] s1_rs,
   input  logic [REG_W-1:0] s1_rt,
   input  logic [REG_W-1:0] s0_rd,
   input  logic [REG_W-1:0] s1_rd,
   input  logic             s0_wr,
   input  logic             s1_wr,
   input  logic             s0_mem,
   input  logic             s1_mem,
   input  logic             s0_cf,
   input  logic             s1_cf,
   input  logic             s0_md,
   input  logic             s1_md,
   input  logic             ex_ld0,
   input  logic             ex_ld1,
   input  logic [REG_W-1:0] ex_rd0,
   input  logic [REG_W-1:0] ex_rd1,
   input  logic             md_ready,
   input  logic             flush,
   output logic             bubble0,
   output logic             bubble1,
   output logic             dec_advance,
   output logic             fetch_stall,
   output logic             md_start,
   output logic             md_abort,
   output logic [CNT_W-1:0] stall_cnt
);

   sched_state_e     state_q, state_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic luse0, luse1, pairblk;
   logic b0_c, b1_c, adv_c, start_c, abort_c;

   // Slot1 writes and slot1 control flow carry no pair hazard on their own.
   logic unused_slot1_flags;
   assign unused_slot1_flags = s1_wr ^ s1_cf;

   issue_hazard_check #(.REG_W(REG_W)) u_hazard (
      .s0_rs   (s0_rs),
      .s0_rt   (s0_rt),
      .s0_rd   (s0_rd),
      .s1_rs   (s1_rs),
      .s1_rt   (s1_rt),
      .s1_rd   (s1_rd),
      .s0_wr   (s0_wr),
      .s0_mem  (s0_mem),
      .s1_mem  (s1_mem),
      .s0_cf   (s0_cf),
      .s0_md   (s0_md),
      .s1_md   (s1_md),
      .ex_ld0  (ex_ld0),
      .ex_ld1  (ex_ld1),
      .ex_rd0  (ex_rd0),
      .ex_rd1  (ex_rd1),
      .luse0   (luse0),
      .luse1   (luse1),
      .pairblk (pairblk)
   );

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      b0_c    = 1'b1;
      b1_c    = 1'b1;
      adv_c   = 1'b0;
      start_c = 1'b0;
      abort_c = 1'b0;

      if (flush) begin
         adv_c   = 1'b1;
         abort_c = (state_q == ST_MD_WAIT);
         state_d = ST_ISSUE;
         pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_ISSUE: begin
               if (!dec_valid) begin
                  adv_c = 1'b1;
               end else if (luse0) begin
                  state_d = ST_ISSUE;
               end else if (s0_md) begin
                  b0_c    = 1'b0;
                  start_c = 1'b1;
                  pend_d  = 1'b1;
                  state_d = ST_MD_WAIT;
               end else if (pairblk || luse1) begin
                  b0_c    = 1'b0;
                  state_d = ST_SPLIT;
               end else if (s1_md) begin
                  b0_c    = 1'b0;
                  b1_c    = 1'b0;
                  start_c = 1'b1;
                  pend_d  = 1'b0;
                  state_d = ST_MD_WAIT;
               end else begin
                  b0_c  = 1'b0;
                  b1_c  = 1'b0;
                  adv_c = 1'b1;
               end
            end
            ST_SPLIT: begin
               if (!luse1) begin
                  b1_c = 1'b0;
                  if (s1_md) begin
                     start_c = 1'b1;
                     pend_d  = 1'b0;
                     state_d = ST_MD_WAIT;
                  end else begin
                     adv_c   = 1'b1;
                     state_d = ST_ISSUE;
                  end
               end
            end
            ST_MD_WAIT: begin
               // The held slot1 only moves on once the unit reports its result.
               if (md_ready) begin
                  pend_d = 1'b0;
                  if (pend_q) begin
                     state_d = ST_SPLIT;
                  end else begin
                     adv_c   = 1'b1;
                     state_d = ST_ISSUE;
                  end
               end
            end
            default: state_d = ST_ISSUE;
         endcase
      end

      stall_cnt_d = stall_cnt_q;
      if (dec_valid && !adv_c && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end

      // While reset is asserted the decode controllers see a quiet, fully bubbled pipe.
      bubble0     = b0_c    || !reset_n;
      bubble1     = b1_c    || !reset_n;
      dec_advance = adv_c   && reset_n;
      md_start    = start_c && reset_n;
      md_abort    = abort_c && reset_n;
      fetch_stall = !dec_advance;
      stall_cnt   = stall_cnt_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= ST_ISSUE;
         pend_q      <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench: a pair-progress reference model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the scheduler.
module tb_dual_issue_scheduler;

   localparam int REG_W = 5;
   localparam int CNT_W = 5;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic             reset_n, dec_valid, md_ready, flush;
   logic [REG_W-1:0] s0_rs, s0_rt, s0_rd, s1_rs, s1_rt, s1_rd, ex_rd0, ex_rd1;
   logic             s0_wr, s1_wr, s0_mem, s1_mem, s0_cf, s1_cf, s0_md, s1_md, ex_ld0, ex_ld1;
   logic             bubble0, bubble1, dec_advance, fetch_stall, md_start, md_abort;
   logic [CNT_W-1:0] stall_cnt;

   dual_issue_scheduler #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset_n(reset_n), .dec_valid(dec_valid),
      .s0_rs(s0_rs), .s0_rt(s0_rt), .s1_rs(s1_rs), .s1_rt(s1_rt),
      .s0_rd(s0_rd), .s1_rd(s1_rd), .s0_wr(s0_wr), .s1_wr(s1_wr),
      .s0_mem(s0_mem), .s1_mem(s1_mem), .s0_cf(s0_cf), .s1_cf(s1_cf),
      .s0_md(s0_md), .s1_md(s1_md), .ex_ld0(ex_ld0), .ex_ld1(ex_ld1),
      .ex_rd0(ex_rd0), .ex_rd1(ex_rd1), .md_ready(md_ready), .flush(flush),
      .bubble0(bubble0), .bubble1(bubble1), .dec_advance(dec_advance),
      .fetch_stall(fetch_stall), .md_start(md_start), .md_abort(md_abort),
      .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic             rst_n, valid;
      logic [REG_W-1:0] s0_rs, s0_rt, s0_rd, s1_rs, s1_rt, s1_rd, ex_rd0, ex_rd1;
      logic             s0_wr, s1_wr, s0_mem, s1_mem, s0_cf, s1_cf, s0_md, s1_md;
      logic             ex_ld0, ex_ld1, md_ready, flush;
   } stim_t;

   typedef struct packed {
      logic b0, b1, adv, fst, start, abort;
   } ctl_t;

   typedef struct {
      ctl_t             ctl;
      logic [CNT_W-1:0] cnt;
      int               tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: progress of the current pair and occupancy of the mult/div unit.
   bit               m_s0_done, m_s1_done, m_busy;
   logic [CNT_W-1:0] m_cnt;

   task automatic check(input string name, input int tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (step %0d): got %h expected %h", name, tag, act, exp);
   endtask

   function automatic bit luse(input stim_t s, input logic [REG_W-1:0] rs,
                               input logic [REG_W-1:0] rt);
      bit hit;
      hit = 1'b0;
      if (s.ex_ld0 && s.ex_rd0 != 0 && (s.ex_rd0 == rs || s.ex_rd0 == rt)) hit = 1'b1;
      if (s.ex_ld1 && s.ex_rd1 != 0 && (s.ex_rd1 == rs || s.ex_rd1 == rt)) hit = 1'b1;
      return hit;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      s.rst_n = 1'b1;
      return s;
   endfunction

   function automatic stim_t pair(input int d0, input int a0, input int b0,
                                  input int d1, input int a1, input int b1);
      stim_t s;
      s = idle();
      s.valid = 1'b1;
      s.s0_rd = REG_W'(d0); s.s0_rs = REG_W'(a0); s.s0_rt = REG_W'(b0); s.s0_wr = 1'b1;
      s.s1_rd = REG_W'(d1); s.s1_rs = REG_W'(a1); s.s1_rt = REG_W'(b1); s.s1_wr = 1'b1;
      return s;
   endfunction

   task automatic clear_pair();
      m_s0_done = 1'b0;
      m_s1_done = 1'b0;
   endtask

   // Slot1 is finished: the pair either waits on the unit or retires from decode.
   task automatic finish_s1(input stim_t s, inout ctl_t c);
      c.b1      = 1'b0;
      m_s1_done = 1'b1;
      if (s.s1_md) begin
         c.start = 1'b1;
         m_busy  = 1'b1;
      end else begin
         c.adv = 1'b1;
         clear_pair();
      end
   endtask

   task automatic step(input stim_t s, input int tag);
      exp_t e;
      ctl_t c;
      bit   hz0, hz1, dep, blk;
      @(posedge clock);
      #1;
      reset_n = s.rst_n; dec_valid = s.valid; md_ready = s.md_ready; flush = s.flush;
      s0_rs = s.s0_rs; s0_rt = s.s0_rt; s0_rd = s.s0_rd;
      s1_rs = s.s1_rs; s1_rt = s.s1_rt; s1_rd = s.s1_rd;
      s0_wr = s.s0_wr; s1_wr = s.s1_wr; s0_mem = s.s0_mem; s1_mem = s.s1_mem;
      s0_cf = s.s0_cf; s1_cf = s.s1_cf; s0_md = s.s0_md; s1_md = s.s1_md;
      ex_ld0 = s.ex_ld0; ex_ld1 = s.ex_ld1; ex_rd0 = s.ex_rd0; ex_rd1 = s.ex_rd1;

      c     = '{b0: 1'b1, b1: 1'b1, adv: 1'b0, fst: 1'b0, start: 1'b0, abort: 1'b0};
      e.cnt = m_cnt;
      e.tag = tag;
      if (!s.rst_n) begin
         clear_pair();
         m_busy = 1'b0;
         m_cnt  = '0;
      end else begin
         hz0 = luse(s, s.s0_rs, s.s0_rt);
         hz1 = luse(s, s.s1_rs, s.s1_rt);
         dep = s.s0_wr && s.s0_rd != 0 &&
               (s.s0_rd == s.s1_rs || s.s0_rd == s.s1_rt || s.s0_rd == s.s1_rd);
         blk = dep || (s.s0_mem && s.s1_mem) || (s.s0_md && s.s1_md) || s.s0_cf;
         if (s.flush) begin
            c.adv   = 1'b1;
            c.abort = m_busy;
            m_busy  = 1'b0;
            clear_pair();
         end else if (m_busy) begin
            if (s.md_ready) begin
               m_busy = 1'b0;
               if (m_s1_done) begin
                  c.adv = 1'b1;
                  clear_pair();
               end
            end
         end else if (!m_s0_done) begin
            if (!s.valid) begin
               c.adv = 1'b1;
            end else if (!hz0) begin
               c.b0      = 1'b0;
               m_s0_done = 1'b1;
               if (s.s0_md) begin
                  c.start = 1'b1;
                  m_busy  = 1'b1;
               end else if (!blk && !hz1) begin
                  finish_s1(s, c);
               end
            end
         end else if (!hz1) begin
            finish_s1(s, c);
         end
         if (s.valid && !c.adv && !s.flush && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      end
      c.fst = !c.adv;
      e.ctl = c;
      sb_q.push_back(e);
   endtask

   // Directed spot check of the counter against a hand-derived value.
   task automatic expect_cnt(input string name, input int v);
      @(negedge clock);
      check(name, -1, 32'(stall_cnt), 32'(v));
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check("ctl{b0,b1,adv,fstall,start,abort}", e.tag,
               32'({bubble0, bubble1, dec_advance, fetch_stall, md_start, md_abort}),
               32'(e.ctl));
         check("stall_cnt", e.tag, 32'(stall_cnt), 32'(e.cnt));
      end
   end

   initial begin
      stim_t s, rst;
      int    tag;
      m_s0_done = 1'b0; m_s1_done = 1'b0; m_busy = 1'b0; m_cnt = '0;
      rst = idle();
      rst.rst_n = 1'b0;
      s = rst;
      reset_n = 1'b0; dec_valid = 1'b0; md_ready = 1'b0; flush = 1'b0;
      {s0_rs, s0_rt, s0_rd, s1_rs, s1_rt, s1_rd, ex_rd0, ex_rd1} = '0;
      {s0_wr, s1_wr, s0_mem, s1_mem, s0_cf, s1_cf, s0_md, s1_md, ex_ld0, ex_ld1} = '0;

      step(rst, 0);
      step(rst, 1);

      // 1: independent adds issue together
      step(pair(1, 4, 5, 2, 6, 7), 10);
      expect_cnt("t1_cnt", 0);

      // 2: RAW inside the pair splits over two cycles
      s = pair(3, 1, 2, 4, 3, 5);
      step(s, 20);
      step(s, 21);

      // 3: load-use on slot0 stalls one cycle
      step(rst, 30);
      s = pair(8, 7, 1, 9, 2, 3);
      s.ex_ld0 = 1'b1; s.ex_rd0 = 5'd7;
      step(s, 31);
      s.ex_ld0 = 1'b0;
      step(s, 32);
      expect_cnt("t3_cnt", 1);

      // 4: mul in slot0, ten cycles of unit latency, then slot1
      step(rst, 40);
      s = pair(10, 11, 12, 13, 14, 15);
      s.s0_md = 1'b1;
      step(s, 41);
      for (int i = 0; i < 9; i++) step(s, 42 + i);
      s.md_ready = 1'b1;
      step(s, 51);
      s.md_ready = 1'b0;
      step(s, 52);
      step(idle(), 53);
      expect_cnt("t4_cnt", 11);

      // 5: flush with md_ready in MD_WAIT aborts and drops slot1
      s = pair(10, 11, 12, 13, 14, 15);
      s.s0_md = 1'b1;
      step(s, 60);
      step(s, 61);
      s.md_ready = 1'b1; s.flush = 1'b1;
      step(s, 62);
      step(pair(1, 2, 3, 4, 5, 6), 63);

      // 6: lw/sw pair splits; reset lands mid-split
      s = pair(1, 2, 3, 0, 4, 5);
      s.s0_mem = 1'b1; s.s1_mem = 1'b1; s.s1_wr = 1'b0;
      step(s, 70);
      step(rst, 71);
      step(s, 72);
      expect_cnt("t6_cnt", 0);
      step(s, 73);

      // Counter saturation under a persistent load-use stall
      step(rst, 80);
      s = pair(8, 7, 1, 9, 2, 3);
      s.ex_ld1 = 1'b1; s.ex_rd1 = 5'd7;
      for (int i = 0; i < 40; i++) step(s, 81);
      expect_cnt("sat_cnt", 31);
      step(rst, 82);

      // Randomized traffic with small register numbers to force collisions
      for (int i = 0; i < 3000; i++) begin
         tag = 1000 + i;
         s = idle();
         s.rst_n    = ($urandom_range(0, 199) != 0);
         s.valid    = ($urandom_range(0, 9) < 8);
         s.s0_rs    = REG_W'($urandom_range(0, 7)); s.s0_rt = REG_W'($urandom_range(0, 7));
         s.s0_rd    = REG_W'($urandom_range(0, 7)); s.s1_rs = REG_W'($urandom_range(0, 7));
         s.s1_rt    = REG_W'($urandom_range(0, 7)); s.s1_rd = REG_W'($urandom_range(0, 7));
         s.ex_rd0   = REG_W'($urandom_range(0, 7)); s.ex_rd1 = REG_W'($urandom_range(0, 7));
         s.s0_wr    = 1'($urandom_range(0, 1));     s.s1_wr = 1'($urandom_range(0, 1));
         s.s0_mem   = ($urandom_range(0, 3) == 0);  s.s1_mem = ($urandom_range(0, 3) == 0);
         s.s0_cf    = ($urandom_range(0, 7) == 0);  s.s1_cf = ($urandom_range(0, 7) == 0);
         s.s0_md    = ($urandom_range(0, 7) == 0);  s.s1_md = ($urandom_range(0, 7) == 0);
         s.ex_ld0   = ($urandom_range(0, 3) == 0);  s.ex_ld1 = ($urandom_range(0, 3) == 0);
         s.md_ready = ($urandom_range(0, 3) == 0);
         s.flush    = ($urandom_range(0, 19) == 0);
         step(s, tag);
      end

      repeat (2) @(negedge clock);
      check("scoreboard_drained", 0, 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
